s_1011gen: RTL and testbench

S_1011GEN -- requirements
Module: s_1011gen

---
 rtl/s_seq_pkg.sv | 13 +
 rtl/s_1011mon.sv | 29 ++
 rtl/s_1011gen.sv | 118 +++++++++++
 tb/tb_s_1011gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/s_seq_pkg.sv
// Shared definitions for the 1011 frame generator: FSM encoding, pattern, counter width.
package s_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         CNT_W   = 8;

endpackage

// File: rtl/s_1011mon.sv
// Overlapping 1011 detector on a serial bit stream; hit flags the cycle carrying the final 1.
module s_1011mon
  import s_seq_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic clr_sync,
  input  logic x,
  output logic hit
);

  // Last three accepted bits; zero history can never alias the leading 1 of the pattern.
  logic [2:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr_sync) hist_d = '0;
    else if (en)  hist_d = {hist_q[1:0], x};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) hist_q <= '0;
    else      hist_q <= hist_d;
  end

  assign hit = en && !clr_sync && ({hist_q, x} == PATTERN);

endmodule

// File: rtl/s_1011gen.sv
// Serial frame generator, MSB first, with registered x/valid/busy/done.
// Optional match counter enabled by macro S_1011GEN_CNT_EN.
module s_1011gen
  import s_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
`ifdef S_1011GEN_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int BW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             accept;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
          sr_d    = data;
          bcnt_d  = BW'(WIDTH - 1);
          x_d     = data[WIDTH-1];
          valid_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        sr_d = sr_q << 1;
        // Terminal count: the last bit is on x this cycle.
        if (bcnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          bcnt_d  = bcnt_q - BW'(1);
          x_d     = sr_q[WIDTH-2];
          valid_d = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = valid_q;
  assign done  = done_q;

`ifdef S_1011GEN_CNT_EN
  logic             hit;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  s_1011mon u_mon (
    .clk      (clk),
    .clr      (clr),
    .en       (valid_q),
    .clr_sync (accept),
    .x        (x_q),
    .hit      (hit)
  );

  always_comb begin
    mcnt_d = mcnt_q;
    if (accept)                  mcnt_d = '0;
    else if (hit && mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) mcnt_q <= '0;
    else      mcnt_q <= mcnt_d;
  end

  assign match_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_s_1011gen.sv
// Directed bench for s_1011gen (WIDTH=16); match_cnt checks compile in with S_1011GEN_CNT_EN.
module tb_s_1011gen;
  import s_seq_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] data;
  logic        x, valid, busy, done;
`ifdef S_1011GEN_CNT_EN
  logic [7:0]  match_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  s_1011gen #(.WIDTH(16)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .data  (data),
    .x     (x),
    .valid (valid),
    .busy  (busy),
    .done  (done)
`ifdef S_1011GEN_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".x"}, 32'(x), 32'd0);
    chk({tag, ".valid"}, 32'(valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
`ifdef S_1011GEN_CNT_EN
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'd0);
`endif
  endtask

  // One frame from IDLE; optional one-cycle start pulse (with data=0) at cycle pulse_at.
  task automatic frame(input logic [15:0] d, input int pulse_at, input logic [7:0] exp_m);
    data  = d;
    start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        chk($sformatf("bit%0d.x", c - 1), 32'(x), 32'(d[16-c]));
        chk("shift.valid", 32'(valid), 32'd1);
        chk("shift.busy", 32'(busy), 32'd1);
        chk("shift.done", 32'(done), 32'd0);
      end else if (c == 17) begin
        chk("done.done", 32'(done), 32'd1);
        chk("done.valid", 32'(valid), 32'd0);
        chk("done.busy", 32'(busy), 32'd0);
        chk("done.x", 32'(x), 32'd0);
      end else begin
        chk("post.valid", 32'(valid), 32'd0);
        chk("post.done", 32'(done), 32'd0);
      end
`ifdef S_1011GEN_CNT_EN
      if (c >= 17) chk("match_cnt", 32'(match_cnt), 32'(exp_m));
`endif
      if (c == 1) start = 1'b0;
      if (pulse_at != 0 && c == pulse_at) begin
        start = 1'b1;
        data  = 16'h0000;
      end
      if (pulse_at != 0 && c == pulse_at + 1) start = 1'b0;
    end
  endtask

  initial begin
    clr   = 1'b0;
    start = 1'b0;
    data  = 16'h0000;

    // Reset held, then released mid-cycle; first start must be taken at the next edge.
    #2  chk_idle("rst_t2");
    #12 chk_idle("rst_t14");
    #7  clr = 1'b1;
    chk_idle("rst_rel");
    frame(16'hB74B, 0, 8'd3);

    frame(16'hFFFF, 0, 8'd0);

    frame(16'hB74B, 5, 8'd3);

    // Back-to-back with start held high.
    data  = 16'hB74B;
    start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        chk($sformatf("b2b1.bit%0d", c - 1), 32'(x), 32'(data == 16'h2D00 ? 1'b0 : 1'b0) | 32'(16'hB74B >> (16 - c) & 16'h1));
        chk("b2b1.valid", 32'(valid), 32'd1);
      end else if (c == 17) begin
        chk("b2b1.done", 32'(done), 32'd1);
      end else if (c == 18) begin
        chk("b2b.gap.valid", 32'(valid), 32'd0);
        chk("b2b.gap.done", 32'(done), 32'd0);
      end else if (c <= 34) begin
        chk($sformatf("b2b2.bit%0d", c - 19), 32'(x), 32'(16'h2D00 >> (34 - c) & 16'h1));
        chk("b2b2.valid", 32'(valid), 32'd1);
      end else if (c == 35) begin
        chk("b2b2.done", 32'(done), 32'd1);
`ifdef S_1011GEN_CNT_EN
        chk("b2b2.match_cnt", 32'(match_cnt), 32'd1);
`endif
      end else begin
        chk("b2b2.post.valid", 32'(valid), 32'd0);
      end
      if (c == 1)  data  = 16'h2D00;
      if (c == 19) start = 1'b0;
    end

    // Mid-frame abort at bit 7.
    data  = 16'hA5C3;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("abort.bit%0d", c - 1), 32'(x), 32'(16'hA5C3 >> (16 - c) & 16'h1));
      if (c == 1) start = 1'b0;
    end
    clr = 1'b0;
    #1 chk_idle("abort.rst");
    #2 clr = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("abort.valid", 32'(valid), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
    end
    frame(16'h5B2D, 0, 8'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
